ycc_mac_sequencer: RTL and testbench
====================================

# ycc_mac_sequencer

Control block that time-shares the single 24-bit floating-point MAC (`fp_mac`) across the nine multiply-accumulate steps of the RGB→YCbCr conversion in the encoder parser stage. It collects the three byte-serial colour samples of each pixel from the imager parser's `rgb_valid` strobe, applies the date-overlay substitution, and steps the MAC through Y, Cb and Cr. For each step it drives the operand byte, coefficient and accumulator source, and it emits the three results in order with a one-cycle `d_qual` qualifier.

## Interface
Parameters:
- `FP_W`, 24: float width, same format as `fp_mac` and `uint2fp`.
- `OVR_BYTE`, 8'hFF: byte substituted for every colour sample of an overlaid pixel.

Ports:
- `clk_in` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `d_in` in 8: colour byte. Order per pixel is R, G, B.
- `rgb_valid` in 1: `d_in` is a valid colour byte this cycle.
- `date_ovr_en` in 1: overlay request, sampled with the R byte of a pixel.
- `mac_out` in FP_W: combinational result from `fp_mac`.
- `rgb_muxed` out 8: operand byte to `uint2fp` → MAC input a.
- `mac_mult` out FP_W: coefficient to MAC input b.
- `mac_acc` out FP_W: accumulator input to the MAC.
- `busy` out 1: sequencer is in RUN.
- `overrun` out 1: sticky. Set when a pixel is dropped.
- `d_qual` out 1: `dout` is valid (one-cycle pulse).
- `dout` out FP_W: result, in component order Y, Cb, Cr.

## Operation
- Byte capture:
  - 2-bit `byte_idx` counts 0→1→2→0 on each `rgb_valid`.
  - Bytes are written into a capture buffer {R,G,B}.
  - `ovr` flag is latched from `date_ovr_en` when `byte_idx`=0.
- Pixel completion: occurs on `rgb_valid` with `byte_idx`=2. The completed pixel goes into a one-entry pending slot {R,G,B,ovr}.
- FSM states IDLE and RUN. The step counter `step` runs 0..8.
  - IDLE → RUN at step 0 when the pending slot is full. The slot moves to the working registers and the slot is freed.
  - In RUN, `step` increments every cycle.
  - At step 8: if the slot is full, reload and go to step 0 with no bubble. Otherwise go to IDLE.
- Step decode:
  - Component c = step/3, term k = step%3.
  - `rgb_muxed` = working[k]. It is OVR_BYTE when ovr=1.
  - `mac_mult` = COEF[c][k].
  - `mac_acc` = OFFSET[c] when k=0, else `acc_reg`.
  - `acc_reg` <= `mac_out` every RUN cycle.
- Output: when k=2, `dout` <= `mac_out` and `d_qual` is asserted for the next cycle.
- Coefficients, stored as FP constants:
  - Y: 0.299, 0.587, 0.114.
  - Cb: −0.168736, −0.331264, 0.5.
  - Cr: 0.5, −0.418688, −0.081312.
  - Offsets: 0, 128, 128.
- Overflow: a completion arriving while the slot is still full sets `overrun`. The new pixel is dropped and the slot keeps its contents.
  - If the slot is freed in the same cycle as a completion (reload at IDLE→RUN or at step 8), the completion is accepted and the flag is not set.
- When IDLE, `rgb_muxed`, `mac_mult` and `mac_acc` are driven to 0.

## Timing
- Reset values:
  - All outputs 0; state IDLE; `byte_idx`=0; slot empty; `overrun`=0.
  - `overrun` is cleared only by `rst`.
- The B byte is sampled at the end of cycle t. Step 0 runs in t+1 when idle.
- `d_qual` pulses at t+4 (Y), t+7 (Cb) and t+10 (Cr).
- Sustained throughput is one pixel per 9 cycles. Completions spaced ≥9 cycles never overrun.
- `busy` is 1 exactly during RUN cycles.
- Reset asserted mid-pixel or mid-sequence:
  - Takes effect immediately and asynchronously.
  - Partial pixels and in-flight results are discarded; no `d_qual` follows.
- The MAC path is combinational within one cycle. No multicycle path is assumed.

## Structure
- Shared package `jpeg_enc_pkg`:
  - `FP_W`.
  - `COEF[3][3]` and `OFFSET[3]` FP encodings.
  - FSM state enum {IDLE, RUN}.
  - Component index constants Y=0, CB=1, CR=2.
- One sub-module, `pixel_gather`: byte counter, capture buffer, ovr latch and pending slot, with a valid/take handshake to the FSM.

## Test plan
- Reset, then R,G,B = 128,128,128 on consecutive cycles → `d_qual` at t+4, t+7, t+10. `dout` equals FP 128.0 for all three, within 1 LSB of the golden model.
- Pixel 255,0,0 with bytes spaced 3 cycles apart → Y≈76.245, Cb≈84.972, Cr≈255.5.
- `date_ovr_en`=1 with the R byte of pixel 10,20,30 → `rgb_muxed` shows only 8'hFF. Outputs are Y=255.0, Cb=128.0, Cr=128.0.
- Three pixels with completions 9 cycles apart → the nine `d_qual` pulses are exactly 3 cycles apart and `busy` never drops. Then complete two pixels within 3 cycles while RUN is at step 2 → `overrun`=1 and only 2 of the 3 pixels produce output.
- Assert `rst` at step 4 → all outputs are 0 in the same cycle. The next full pixel produces correct results starting from `byte_idx`=0.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared encoder types and constants: FP24 colour-conversion coefficients,
// sequencer state encoding and step-to-component/term decode helpers.
package jpeg_enc_pkg;

  localparam int unsigned FP_W = 24;
  localparam logic [3:0] LAST_STEP = 4'd8;

  localparam logic [1:0] Y  = 2'd0;
  localparam logic [1:0] CB = 2'd1;
  localparam logic [1:0] CR = 2'd2;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       ovr;
  } pixel_t;

  // FP24 = sign, 8-bit exponent (bias 127), 15-bit fraction; row = component, column = term
  localparam logic [FP_W-1:0] COEF [3][3] = '{
    '{24'h3E9917, 24'h3F1646, 24'h3DE979},   //  0.299,     0.587,     0.114
    '{24'hBE2CC9, 24'hBEA99B, 24'h3F0000},   // -0.168736, -0.331264,  0.5
    '{24'h3F0000, 24'hBED65E, 24'hBDA687}    //  0.5,      -0.418688, -0.081312
  };

  localparam logic [FP_W-1:0] OFFSET [3] = '{24'h000000, 24'h430000, 24'h430000};

  function automatic logic [1:0] step_comp(input logic [3:0] step);
    logic [1:0] c;
    case (step)
      4'd0, 4'd1, 4'd2: c = Y;
      4'd3, 4'd4, 4'd5: c = CB;
      default:          c = CR;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] step_term(input logic [3:0] step);
    logic [1:0] k;
    case (step)
      4'd0, 4'd3, 4'd6: k = 2'd0;
      4'd1, 4'd4, 4'd7: k = 2'd1;
      default:          k = 2'd2;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] pixel_byte(input pixel_t p, input logic [1:0] k);
    logic [7:0] v;
    case (k)
      2'd0:    v = p.r;
      2'd1:    v = p.g;
      default: v = p.b;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pixel_gather.sv
// Assembles byte-serial R,G,B samples into pixels and holds one pending pixel
// for the sequencer; a completing pixel is offered combinationally when the slot is empty.
module pixel_gather
  import jpeg_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic       rgb_valid,
  input  logic       date_ovr_en,
  input  logic       take,
  output logic       valid_c,
  output pixel_t     pix_c,
  output logic       overrun
);

  logic [1:0] byte_idx;
  logic [7:0] cap_r;
  logic [7:0] cap_g;
  logic       cap_ovr;
  pixel_t     slot;
  logic       slot_full;
  logic       complete_c;
  pixel_t     new_pix_c;

  assign complete_c = rgb_valid && (byte_idx == 2'd2);
  assign new_pix_c  = '{r: cap_r, g: cap_g, b: d_in, ovr: cap_ovr};
  assign valid_c    = slot_full || complete_c;
  assign pix_c      = slot_full ? slot : new_pix_c;

  // Byte counter and capture buffer; overlay request is taken with the R byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      cap_r    <= 8'd0;
      cap_g    <= 8'd0;
      cap_ovr  <= 1'b0;
    end else if (rgb_valid) begin
      case (byte_idx)
        2'd0: begin
          cap_r    <= d_in;
          cap_ovr  <= date_ovr_en;
          byte_idx <= 2'd1;
        end
        2'd1: begin
          cap_g    <= d_in;
          byte_idx <= 2'd2;
        end
        default: byte_idx <= 2'd0;
      endcase
    end
  end

  // Pending slot: an empty slot with a same-cycle take lets the pixel bypass straight through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= '0;
      slot_full <= 1'b0;
      overrun   <= 1'b0;
    end else if (slot_full) begin
      if (take) begin
        slot_full <= complete_c;
        if (complete_c) slot <= new_pix_c;
      end else if (complete_c) begin
        overrun <= 1'b1;
      end
    end else if (complete_c && !take) begin
      slot      <= new_pix_c;
      slot_full <= 1'b1;
    end
  end

endmodule

// File: rtl/ycc_mac_sequencer.sv
// Time-shares one FP multiply-accumulate over the nine RGB->YCbCr terms of
// each pixel and emits Y, Cb, Cr with a one-cycle d_qual strobe.
module ycc_mac_sequencer #(
  parameter int unsigned FP_W     = 24,
  parameter logic [7:0]  OVR_BYTE = 8'hFF
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [7:0]      d_in,
  input  logic            rgb_valid,
  input  logic            date_ovr_en,
  input  logic [FP_W-1:0] mac_out,
  output logic [7:0]      rgb_muxed,
  output logic [FP_W-1:0] mac_mult,
  output logic [FP_W-1:0] mac_acc,
  output logic            busy,
  output logic            overrun,
  output logic            d_qual,
  output logic [FP_W-1:0] dout
);
  import jpeg_enc_pkg::*;

  state_t          state, nxt_state;
  logic [3:0]      step, nxt_step;
  pixel_t          work, nxt_work;
  pixel_t          pix_c;
  logic            valid_c;
  logic            take_c;
  logic [1:0]      nxt_c, nxt_k;
  logic [7:0]      nxt_rgb;
  logic [FP_W-1:0] nxt_mult;
  logic [FP_W-1:0] nxt_acc;
  logic            res_step_c;

  pixel_gather u_gather (
    .clk         (clk_in),
    .rst         (rst),
    .d_in        (d_in),
    .rgb_valid   (rgb_valid),
    .date_ovr_en (date_ovr_en),
    .take        (take_c),
    .valid_c     (valid_c),
    .pix_c       (pix_c),
    .overrun     (overrun)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next state plus the MAC operands for the step that the next cycle will run
  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    nxt_work  = work;
    take_c    = 1'b0;
    nxt_rgb   = 8'd0;
    nxt_mult  = '0;
    nxt_acc   = '0;
    case (state)
      IDLE: begin
        if (valid_c) begin
          take_c    = 1'b1;
          nxt_state = RUN;
          nxt_step  = 4'd0;
          nxt_work  = pix_c;
        end
      end
      RUN: begin
        if (step == LAST_STEP) begin
          nxt_step = 4'd0;
          if (valid_c) begin
            take_c   = 1'b1;
            nxt_work = pix_c;
          end else begin
            nxt_state = IDLE;
          end
        end else begin
          nxt_step = 4'(step + 4'd1);
        end
      end
      default: nxt_state = IDLE;
    endcase
    nxt_c = step_comp(nxt_step);
    nxt_k = step_term(nxt_step);
    if (nxt_state == RUN) begin
      nxt_rgb  = nxt_work.ovr ? OVR_BYTE : pixel_byte(nxt_work, nxt_k);
      nxt_mult = FP_W'(COEF[nxt_c][nxt_k]);
      // mac_acc doubles as the running accumulator between terms
      nxt_acc  = (nxt_k == 2'd0) ? FP_W'(OFFSET[nxt_c]) : mac_out;
    end
  end

  assign res_step_c = (state == RUN) && (step_term(step) == 2'd2);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      step      <= 4'd0;
      work      <= '0;
      rgb_muxed <= 8'd0;
      mac_mult  <= '0;
      mac_acc   <= '0;
      busy      <= 1'b0;
      d_qual    <= 1'b0;
      dout      <= '0;
    end else begin
      step      <= nxt_step;
      work      <= nxt_work;
      rgb_muxed <= nxt_rgb;
      mac_mult  <= nxt_mult;
      mac_acc   <= nxt_acc;
      busy      <= (nxt_state == RUN);
      d_qual    <= res_step_c;
      if (res_step_c) dout <= mac_out;
    end
  end

endmodule

// File: tb/tb_ycc_mac_sequencer.sv
// Directed bench for ycc_mac_sequencer with a real-valued stand-in for the FP24 MAC.
module tb_ycc_mac_sequencer;

  localparam real TOL = 0.02;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [7:0]  d_in;
  logic        rgb_valid;
  logic        date_ovr_en;
  logic [23:0] mac_out;
  logic [7:0]  rgb_muxed;
  logic [23:0] mac_mult;
  logic [23:0] mac_acc;
  logic        busy;
  logic        overrun;
  logic        d_qual;
  logic [23:0] dout;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [23:0] q_val[$];
  int          q_cyc[$];
  int          busy_low[$];

  ycc_mac_sequencer #(.FP_W(24), .OVR_BYTE(8'hFF)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .d_in        (d_in),
    .rgb_valid   (rgb_valid),
    .date_ovr_en (date_ovr_en),
    .mac_out     (mac_out),
    .rgb_muxed   (rgb_muxed),
    .mac_mult    (mac_mult),
    .mac_acc     (mac_acc),
    .busy        (busy),
    .overrun     (overrun),
    .d_qual      (d_qual),
    .dout        (dout)
  );

  initial forever #5 clk_in = ~clk_in;

  function automatic real fp_decode(input logic [23:0] x);
    real v;
    int  e;
    if (x[22:15] == 8'd0) return 0.0;
    v = 1.0 + real'(x[14:0]) / 32768.0;
    e = int'(x[22:15]) - 127;
    for (int i = 0; i < e; i++) v = v * 2.0;
    for (int i = 0; i > e; i--) v = v / 2.0;
    return x[23] ? -v : v;
  endfunction

  function automatic logic [23:0] fp_encode(input real v);
    logic [63:0] b;
    logic [22:0] mag;
    int          e;
    if (v == 0.0) return 24'd0;
    b   = $realtobits(v);
    e   = int'(b[62:52]) - 896;
    mag = {8'(e), b[51:37]};
    mag = 23'(mag + 23'(b[36]));
    return {b[63], mag};
  endfunction

  always_comb mac_out = fp_encode(real'(rgb_muxed) * fp_decode(mac_mult) + fp_decode(mac_acc));

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (d_qual) begin
      q_val.push_back(dout);
      q_cyc.push_back(cyc);
    end
    if (!busy) busy_low.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_fp(input string tag, input logic [23:0] obs, input real expv);
    real o;
    real d;
    o = fp_decode(obs);
    d = o - expv;
    if (d < 0.0) d = -d;
    n_chk++;
    assert ((d < TOL) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %f expected %f", tag, o, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic o);
    d_in        = b;
    date_ovr_en = o;
    rgb_valid   = 1'b1;
    tick();
    rgb_valid   = 1'b0;
    date_ovr_en = 1'b0;
    d_in        = 8'd0;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic o, output int tb);
    send_byte(r, o);
    send_byte(g, 1'b0);
    tb = cyc;
    send_byte(b, 1'b0);
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (q_val.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk_eq({tag, "_timeout"}, 32'(q_val.size() >= n), 32'd1);
  endtask

  task automatic chk_result(input string tag, input real expv, input int exp_cyc);
    logic [23:0] v;
    int          c;
    if (q_val.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s: observed no result expected %f", tag, expv);
    end else begin
      v = q_val.pop_front();
      c = q_cyc.pop_front();
      chk_fp(tag, v, expv);
      chk_eq({tag, "_cyc"}, 32'(c), 32'(exp_cyc));
    end
  endtask

  initial begin
    int tb, tb1, tb2, late;
    rst = 1'b1; d_in = 8'd0; rgb_valid = 1'b0; date_ovr_en = 1'b0;
    #3;
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_dqual", 32'(d_qual), 32'd0);
    chk_eq("rst_dout", 32'(dout), 32'd0);
    chk_eq("rst_rgb", 32'(rgb_muxed), 32'd0);
    chk_eq("rst_mult", 32'(mac_mult), 32'd0);
    chk_eq("rst_acc", 32'(mac_acc), 32'd0);
    chk_eq("rst_overrun", 32'(overrun), 32'd0);
    tick(); tick();
    #1 rst = 1'b0;
    tick();

    // Grey pixel on consecutive cycles
    send_pixel(8'd128, 8'd128, 8'd128, 1'b0, tb);
    chk_eq("grey_busy", 32'(busy), 32'd1);
    chk_eq("grey_rgb0", 32'(rgb_muxed), 32'd128);
    chk_eq("grey_mult0", 32'(mac_mult), 32'h3E9917);
    chk_eq("grey_acc0", 32'(mac_acc), 32'd0);
    tick();
    chk_eq("grey_mult1", 32'(mac_mult), 32'h3F1646);
    wait_q("grey", 3, 40);
    chk_result("grey_y", 128.0, tb + 4);
    chk_result("grey_cb", 128.0, tb + 7);
    chk_result("grey_cr", 128.0, tb + 10);
    tick();
    chk_eq("idle_busy", 32'(busy), 32'd0);
    chk_eq("idle_mult", 32'(mac_mult), 32'd0);
    chk_eq("idle_acc", 32'(mac_acc), 32'd0);

    // Red pixel with bytes three cycles apart
    send_byte(8'd255, 1'b0); tick(); tick();
    send_byte(8'd0, 1'b0); tick(); tick();
    tb = cyc;
    send_byte(8'd0, 1'b0);
    wait_q("red", 3, 40);
    chk_result("red_y", 76.245, tb + 4);
    chk_result("red_cb", 84.97232, tb + 7);
    chk_result("red_cr", 255.5, tb + 10);

    // Date overlay forces every operand byte to FF
    tick();
    send_pixel(8'd10, 8'd20, 8'd30, 1'b1, tb);
    chk_eq("ovr_rgb0", 32'(rgb_muxed), 32'hFF);
    tick();
    chk_eq("ovr_rgb1", 32'(rgb_muxed), 32'hFF);
    tick();
    chk_eq("ovr_rgb2", 32'(rgb_muxed), 32'hFF);
    wait_q("ovr", 3, 40);
    chk_result("ovr_y", 255.0, tb + 4);
    chk_result("ovr_cb", 128.0, tb + 7);
    chk_result("ovr_cr", 128.0, tb + 10);

    // Three pixels completing exactly nine cycles apart
    tick(); tick();
    q_val.delete(); q_cyc.delete();
    send_pixel(8'd0, 8'd255, 8'd0, 1'b0, tb);
    busy_low.delete();
    repeat (6) tick();
    send_pixel(8'd0, 8'd0, 8'd255, 1'b0, tb1);
    repeat (6) tick();
    send_pixel(8'd128, 8'd128, 8'd128, 1'b0, tb2);
    chk_eq("sus_spacing", 32'(tb2 - tb), 32'd18);
    wait_q("sus", 9, 60);
    chk_result("sus_g_y", 149.685, tb + 4);
    chk_result("sus_g_cb", 43.52768, tb + 7);
    chk_result("sus_g_cr", 21.23456, tb + 10);
    chk_result("sus_b_y", 29.07, tb + 13);
    chk_result("sus_b_cb", 255.5, tb + 16);
    chk_result("sus_b_cr", 107.26544, tb + 19);
    chk_result("sus_w_y", 128.0, tb + 22);
    chk_result("sus_w_cb", 128.0, tb + 25);
    chk_result("sus_w_cr", 128.0, tb + 28);
    late = 0;
    foreach (busy_low[i]) if (busy_low[i] <= tb2 + 9) late++;
    chk_eq("sus_busy_drop", 32'(late), 32'd0);
    chk_eq("sus_end_busy", 32'(busy), 32'd0);
    chk_eq("sus_overrun", 32'(overrun), 32'd0);

    // Back-to-back pixels: third completion finds the slot full and is dropped
    tick();
    q_val.delete(); q_cyc.delete();
    send_pixel(8'd255, 8'd0, 8'd0, 1'b0, tb);
    send_pixel(8'd0, 8'd255, 8'd0, 1'b0, tb1);
    chk_eq("ovf_before", 32'(overrun), 32'd0);
    send_pixel(8'd0, 8'd0, 8'd255, 1'b0, tb2);
    chk_eq("ovf_set", 32'(overrun), 32'd1);
    wait_q("ovf", 6, 60);
    repeat (20) tick();
    chk_eq("ovf_count", 32'(q_val.size()), 32'd6);
    chk_result("ovf_r_y", 76.245, tb + 4);
    chk_result("ovf_r_cb", 84.97232, tb + 7);
    chk_result("ovf_r_cr", 255.5, tb + 10);
    chk_result("ovf_g_y", 149.685, tb + 13);
    chk_result("ovf_g_cb", 43.52768, tb + 16);
    chk_result("ovf_g_cr", 21.23456, tb + 19);
    chk_eq("ovf_sticky", 32'(overrun), 32'd1);

    // Reset at step 4 with a partial next pixel already captured
    q_val.delete(); q_cyc.delete();
    send_pixel(8'd255, 8'd0, 8'd0, 1'b0, tb);
    send_byte(8'd1, 1'b0);
    send_byte(8'd2, 1'b0);
    tick(); tick();
    chk_eq("mid_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    chk_eq("mid_rst_dout", 32'(dout), 32'd0);
    chk_eq("mid_rst_rgb", 32'(rgb_muxed), 32'd0);
    chk_eq("mid_rst_mult", 32'(mac_mult), 32'd0);
    chk_eq("mid_rst_acc", 32'(mac_acc), 32'd0);
    chk_eq("mid_rst_overrun", 32'(overrun), 32'd0);
    q_val.delete(); q_cyc.delete();
    tick();
    #1 rst = 1'b0;
    repeat (10) tick();
    chk_eq("mid_no_qual", 32'(q_val.size()), 32'd0);
    send_pixel(8'd0, 8'd255, 8'd0, 1'b0, tb);
    wait_q("post", 3, 40);
    chk_result("post_y", 149.685, tb + 4);
    chk_result("post_cb", 43.52768, tb + 7);
    chk_result("post_cr", 21.23456, tb + 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
